// File: rtl/mc_datapath.sv
// Multicycle MIPS-style datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with
// req/ack instruction and data memory ports; control comes from an external decoder.
module mc_datapath #(
   parameter int          DATA_W   = 32,
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          NREG     = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [1:0]        RegDst,
   input  logic              ALUSrc,
   input  logic [1:0]        DataSrc,
   input  logic              RegWrite,
   input  logic              MemWrite,
   input  logic [1:0]        NPC_Sel,
   input  logic [1:0]        ExtOp,
   input  logic [2:0]        ALUOp,
   output logic [31:0]       Instr,
   output logic [2:0]        Phase,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [31:0]       dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              retire,
   output logic [31:0]       retire_pc
);
   localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t            state;
   logic [31:0]       pc, pc4, ir;
   logic [DATA_W-1:0] a, b, alu_out, mdr;
   logic              z;
   logic [DATA_W-1:0] rf [NREG];

   logic [RW-1:0]     rs_idx, rt_idx, rd_idx, wb_idx;
   logic [DATA_W-1:0] rd_a, rd_b, ext, alu_b, alu_res, wb_data;
   logic [31:0]       br_off, npc;
   logic              wb_en, mem_op;

   assign rs_idx = ir[21 +: RW];
   assign rt_idx = ir[16 +: RW];
   assign rd_idx = ir[11 +: RW];
   assign rd_a   = (rs_idx == '0) ? '0 : rf[rs_idx];
   assign rd_b   = (rt_idx == '0) ? '0 : rf[rt_idx];
   assign alu_b  = ALUSrc ? ext : b;
   assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};
   assign mem_op = MemWrite || (DataSrc == 2'b01);

   always_comb begin
      ext = '0;
      case (ExtOp)
         2'b00:   ext = DATA_W'(ir[15:0]);
         2'b01:   ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
         2'b10:   ext = DATA_W'({ir[15:0], 16'h0000});
         default: ext = '0;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (ALUOp)
         3'b000: alu_res = a + alu_b;
         3'b001: alu_res = a - alu_b;
         3'b010: alu_res = a | alu_b;
         3'b011: alu_res = a & alu_b;
         3'b100: alu_res = a ^ alu_b;
         3'b101: alu_res = DATA_W'($signed(a) < $signed(alu_b));
         3'b110: alu_res = DATA_W'(a < alu_b);
         3'b111: alu_res = alu_b;
         default: alu_res = '0;
      endcase
   end

   // Undefined RegDst selects index 0, which the write enable then discards.
   always_comb begin
      wb_idx  = '0;
      wb_data = '0;
      npc     = pc4;
      case (RegDst)
         2'b00:   wb_idx = rd_idx;
         2'b01:   wb_idx = rt_idx;
         2'b10:   wb_idx = RW'(31);
         default: wb_idx = '0;
      endcase
      case (DataSrc)
         2'b00:   wb_data = alu_out;
         2'b01:   wb_data = mdr;
         2'b10:   wb_data = DATA_W'(pc4);
         default: wb_data = '0;
      endcase
      case (NPC_Sel)
         2'b00: npc = pc4;
         2'b01: npc = z ? (pc4 + br_off) : pc4;
         2'b10: npc = {pc4[31:28], ir[25:0], 2'b00};
         2'b11: npc = a[31:0];
         default: npc = pc4;
      endcase
   end

   assign wb_en = RegWrite && (wb_idx != '0);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= FETCH;
         pc       <= PC_RESET;
         pc4      <= '0;
         ir       <= '0;
         a        <= '0;
         b        <= '0;
         alu_out  <= '0;
         mdr      <= '0;
         z        <= 1'b0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         retire   <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               // After reset req is still low, so the first FETCH cycle only raises it.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= imem_rdata;
                  pc4      <= pc + 32'd4;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               a     <= rd_a;
               b     <= rd_b;
               state <= EXEC;
            end
            EXEC: begin
               alu_out <= alu_res;
               z       <= (a == b);
               if (mem_op) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= MemWrite;
                  state    <= MEM;
               end else begin
                  retire <= 1'b1;
                  state  <= WB;
               end
            end
            MEM: begin
               if (dmem_req && dmem_ack) begin
                  if (DataSrc == 2'b01) mdr <= dmem_rdata;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  retire   <= 1'b1;
                  state    <= WB;
               end
            end
            WB: begin
               if (wb_en) rf[wb_idx] <= wb_data;
               pc       <= npc;
               retire   <= 1'b0;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign Instr      = ir;
   assign Phase      = state;
   assign imem_addr  = pc;
   assign dmem_addr  = {alu_out[31:2], 2'b00};
   assign dmem_wdata = b;
   assign retire_pc  = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: drives a small MIPS program through handshake
// memories and a behavioural controller, checking retire timing and memory traffic.
module tb_mc_datapath;
   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  RegDst, DataSrc, NPC_Sel, ExtOp;
   logic        ALUSrc, RegWrite, MemWrite;
   logic [2:0]  ALUOp;
   logic [31:0] Instr;
   logic [2:0]  Phase;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        retire;
   logic [31:0] retire_pc;

   int cyc = 0;
   int total = 0;
   int passed = 0;

   mc_datapath dut (
      .Clk(Clk), .Reset(Reset),
      .RegDst(RegDst), .ALUSrc(ALUSrc), .DataSrc(DataSrc), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .NPC_Sel(NPC_Sel), .ExtOp(ExtOp), .ALUOp(ALUOp),
      .Instr(Instr), .Phase(Phase),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .retire(retire), .retire_pc(retire_pc)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Behavioural controller for the handful of opcodes the program uses.
   always_comb begin
      RegDst = 2'b00; ALUSrc = 1'b0; DataSrc = 2'b00; RegWrite = 1'b0;
      MemWrite = 1'b0; NPC_Sel = 2'b00; ExtOp = 2'b00; ALUOp = 3'b000;
      case (Instr[31:26])
         6'h00: begin
            if (Instr[5:0] == 6'h21) RegWrite = 1'b1;
            if (Instr[5:0] == 6'h08) NPC_Sel = 2'b11;
         end
         6'h0D: begin RegDst = 2'b01; ALUSrc = 1'b1; ALUOp = 3'b010; RegWrite = 1'b1; end
         6'h23: begin RegDst = 2'b01; ALUSrc = 1'b1; ExtOp = 2'b01; DataSrc = 2'b01; RegWrite = 1'b1; end
         6'h2B: begin ALUSrc = 1'b1; ExtOp = 2'b01; MemWrite = 1'b1; end
         6'h04: begin NPC_Sel = 2'b01; ALUOp = 3'b001; end
         6'h03: begin RegDst = 2'b10; DataSrc = 2'b10; RegWrite = 1'b1; NPC_Sel = 2'b10; end
         6'h02: NPC_Sel = 2'b10;
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Runs one instruction from its FETCH cycle through WB; leaves the bench at the next FETCH.
   task automatic run(input string tag, input logic [31:0] pc, input logic [31:0] word,
                      input int iwait, input int dwait, input logic [31:0] drd, input int exp_len,
                      output int ret_cyc, output int mcyc, output logic mwe,
                      output logic [31:0] maddr, output logic [31:0] mwdata, output logic [31:0] npc);
      int k = 0;
      int c0;
      while (!imem_req && k < 20) begin @(negedge Clk); k++; end
      chk({tag, "_ireq"}, 32'(imem_req), 32'd1);
      chk({tag, "_iaddr"}, imem_addr, pc);
      c0 = cyc;
      repeat (iwait) @(negedge Clk);
      imem_ack = 1'b1; imem_rdata = word;
      @(negedge Clk);
      imem_ack = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge Clk);
      mcyc = 0; mwe = 1'b0; maddr = '0; mwdata = '0;
      if (dmem_req) begin
         mwe = dmem_we; maddr = dmem_addr; mwdata = dmem_wdata;
      end
      k = 0;
      while (dmem_req && k < 64) begin
         k++;
         if (k > dwait) begin dmem_ack = 1'b1; dmem_rdata = drd; end
         @(negedge Clk);
         dmem_ack = 1'b0; dmem_rdata = '0;
      end
      mcyc = k;
      chk({tag, "_retire"}, 32'(retire), 32'd1);
      chk({tag, "_rpc"}, retire_pc, pc);
      chk({tag, "_len"}, 32'(cyc - c0 + 1), 32'(exp_len));
      ret_cyc = cyc;
      @(negedge Clk);
      chk({tag, "_pulse"}, 32'(retire), 32'd0);
      npc = imem_addr;
   endtask

   initial begin
      int r1, r2, mc;
      logic we;
      logic [31:0] ad, wd, np;
      Reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (3) @(negedge Clk);
      chk("rst_phase", 32'(Phase), 32'd0);
      chk("rst_ireq", 32'(imem_req), 32'd0);
      chk("rst_dreq", 32'(dmem_req), 32'd0);
      chk("rst_ir", Instr, 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_pc", imem_addr, 32'h3000);
      Reset = 1'b1;

      // ori $5,$0,7 with one fetch wait cycle, then a stalled fetch killed by reset
      run("pre", 32'h3000, 32'h34050007, 1, 0, 0, 5, r1, mc, we, ad, wd, np);
      chk("pre_npc", np, 32'h3004);
      repeat (3) @(negedge Clk);
      chk("stall_phase", 32'(Phase), 32'd0);
      chk("stall_ireq", 32'(imem_req), 32'd1);
      Reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h34011234;
      @(negedge Clk);
      Reset = 1'b1;
      chk("mrst_ir", Instr, 32'd0);
      chk("mrst_pc", imem_addr, 32'h3000);
      chk("mrst_ireq", 32'(imem_req), 32'd0);
      chk("mrst_phase", 32'(Phase), 32'd0);
      @(negedge Clk);
      chk("mrst_ireq_up", 32'(imem_req), 32'd1);
      chk("mrst_ir_ign", Instr, 32'd0);
      imem_ack = 1'b0; imem_rdata = '0;

      run("ori", 32'h3000, 32'h34011234, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      run("addu", 32'h3004, 32'h00211021, 0, 0, 0, 4, r2, mc, we, ad, wd, np);
      chk("retire_gap", 32'(r2 - r1), 32'd4);
      run("sw2", 32'h3008, 32'hAC020008, 0, 3, 0, 8, r1, mc, we, ad, wd, np);
      chk("sw2_mcyc", 32'(mc), 32'd4);
      chk("sw2_we", 32'(we), 32'd1);
      chk("sw2_addr", ad, 32'h8);
      chk("sw2_wdata", wd, 32'h2468);
      run("lw3", 32'h300C, 32'h8C030008, 0, 0, 32'hDEADBEEF, 5, r1, mc, we, ad, wd, np);
      chk("lw3_we", 32'(we), 32'd0);
      chk("lw3_addr", ad, 32'h8);
      run("beq_t", 32'h3010, 32'h1021FFFF, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      chk("beq_t_npc", np, 32'h3010);
      run("beq_n", 32'h3010, 32'h10220003, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      chk("beq_n_npc", np, 32'h3014);
      run("addu0", 32'h3014, 32'h00630021, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      run("sw0", 32'h3018, 32'hAC000004, 0, 1, 0, 6, r1, mc, we, ad, wd, np);
      chk("sw0_addr", ad, 32'h4);
      chk("sw0_wdata", wd, 32'h0);
      run("sw3", 32'h301C, 32'hAC030000, 0, 0, 0, 5, r1, mc, we, ad, wd, np);
      chk("sw3_wdata", wd, 32'hDEADBEEF);
      run("jal", 32'h3020, 32'h0C000C01, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      chk("jal_npc", np, 32'h3004);
      run("jr", 32'h3004, 32'h03E00008, 0, 0, 0, 4, r1, mc, we, ad, wd, np);
      chk("jr_npc", np, 32'h3024);
      run("sw31", 32'h3024, 32'hAC1F000C, 0, 0, 0, 5, r1, mc, we, ad, wd, np);
      chk("sw31_addr", ad, 32'hC);
      chk("sw31_wdata", wd, 32'h3024);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
